// File: rtl/regfile_param_if.sv
// Register file bus: WB write port, two ID read ports with hazard flags, decode issue port.
interface regfile_param_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] WriteRegister;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [ADDR_WIDTH-1:0] ReadRegister1;
  logic [ADDR_WIDTH-1:0] ReadRegister2;
  logic [DATA_WIDTH-1:0] ReadData1;
  logic [DATA_WIDTH-1:0] ReadData2;
  logic                  IssueValid;
  logic [ADDR_WIDTH-1:0] IssueRegister;
  logic                  Pending1;
  logic                  Pending2;
  logic                  ready;

  modport master (
    output RegWrite, WriteRegister, WriteData,
    output ReadRegister1, ReadRegister2,
    output IssueValid, IssueRegister,
    input  ReadData1, ReadData2, Pending1, Pending2, ready
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData,
    input  ReadRegister1, ReadRegister2,
    input  IssueValid, IssueRegister,
    output ReadData1, ReadData2, Pending1, Pending2, ready
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised pipeline register file with clear sequencer and pending scoreboard.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module regfile_param #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_EN    = 1,
  parameter int ZERO_REG   = 31
) (
  input  logic           clk,
  input  logic           reset,
  regfile_param_if.slave rf
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] ZIDX = ADDR_WIDTH'(ZERO_REG);

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] idx);
    return (ZERO_EN != 0) && (idx == ZIDX);
  endfunction

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_nxt;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  run;
  logic                  wr_en;
  logic                  iss_en;
  logic                  byp1;
  logic                  byp2;

  assign run    = (state == RUN);
  assign wr_en  = run && rf.RegWrite && !is_zero(rf.WriteRegister);
  assign iss_en = run && rf.IssueValid && !is_zero(rf.IssueRegister);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
      pending <= '0;
    end else begin
      pending <= pending_nxt;
      if (!run) begin
        clr_idx <= clr_idx + 1'b1;
        if (&clr_idx) state <= RUN;
      end
    end
  end

  // Issue is applied after the write-clear so the newer producer stays outstanding.
  always_comb begin
    pending_nxt = pending;
    if (wr_en)  pending_nxt[rf.WriteRegister] = 1'b0;
    if (iss_en) pending_nxt[rf.IssueRegister] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!run)       regs[clr_idx]          <= '0;
      else if (wr_en) regs[rf.WriteRegister] <= rf.WriteData;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign byp1 = wr_en && (rf.WriteRegister == rf.ReadRegister1);
  assign byp2 = wr_en && (rf.WriteRegister == rf.ReadRegister2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_comb begin
    rf.ReadData1 = '0;
    rf.ReadData2 = '0;
    if (run && !is_zero(rf.ReadRegister1))
      rf.ReadData1 = byp1 ? rf.WriteData : regs[rf.ReadRegister1];
    if (run && !is_zero(rf.ReadRegister2))
      rf.ReadData2 = byp2 ? rf.WriteData : regs[rf.ReadRegister2];
  end

  assign rf.Pending1 = run && pending[rf.ReadRegister1] && !byp1;
  assign rf.Pending2 = run && pending[rf.ReadRegister2] && !byp2;
  assign rf.ready    = run;
endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: clear sequence, vector table in RUN, reset corner cases.
module tb_regfile_param;
  localparam int DW = 64;
  localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  regfile_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

  regfile_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_EN(1), .ZERO_REG(31))
    dut (.clk(clk), .reset(reset), .rf(bus.slave));
  regfile_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_EN(0), .ZERO_REG(31))
    dut_nz (.clk(clk), .reset(reset), .rf(bus2.slave));

  typedef struct {
    logic          rw;
    logic [AW-1:0] wr;
    logic [DW-1:0] wd;
    logic [AW-1:0] rr1;
    logic [AW-1:0] rr2;
    logic          iv;
    logic [AW-1:0] ir;
    logic [DW-1:0] e_rd1;
    logic [DW-1:0] e_rd2;
    logic          e_p1;
    logic          e_p2;
  } vec_t;

  vec_t vt[14];
  int vectors = 0;
  int miscompares = 0;

  function automatic vec_t mk(logic rw, int wr, logic [DW-1:0] wd, int rr1, int rr2,
                              logic iv, int ir, logic [DW-1:0] e1, logic [DW-1:0] e2,
                              logic p1, logic p2);
    vec_t v;
    v.rw = rw; v.wr = AW'(wr); v.wd = wd; v.rr1 = AW'(rr1); v.rr2 = AW'(rr2);
    v.iv = iv; v.ir = AW'(ir); v.e_rd1 = e1; v.e_rd2 = e2; v.e_p1 = p1; v.e_p2 = p2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.RegWrite = 1'b0; bus.WriteRegister = '0; bus.WriteData = '0;
    bus.ReadRegister1 = '0; bus.ReadRegister2 = '0;
    bus.IssueValid = 1'b0; bus.IssueRegister = '0;
    bus2.RegWrite = 1'b0; bus2.WriteRegister = '0; bus2.WriteData = '0;
    bus2.ReadRegister1 = '0; bus2.ReadRegister2 = '0;
    bus2.IssueValid = 1'b0; bus2.IssueRegister = '0;
  endtask

  // Called at a negedge with reset just released; counts edges until ready.
  task automatic wait_ready(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      n++;
      if (bus.ready) break;
    end
  endtask

  task automatic write_issue(input int wr, input logic [DW-1:0] wd, input logic iv, input int ir);
    @(negedge clk);
    idle();
    bus.RegWrite = 1'b1; bus.WriteRegister = AW'(wr); bus.WriteData = wd;
    bus.IssueValid = iv; bus.IssueRegister = AW'(ir);
    @(negedge clk);
    idle();
  endtask

  task automatic read_chk(input string nm, input int r1, input int r2,
                          input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                          input logic p1, input logic p2);
    @(negedge clk);
    idle();
    bus.ReadRegister1 = AW'(r1); bus.ReadRegister2 = AW'(r2);
    #1;
    vectors++;
    chk({nm, ".rd1"}, bus.ReadData1, e1);
    chk({nm, ".rd2"}, bus.ReadData2, e2);
    chk({nm, ".p1"}, DW'(bus.Pending1), DW'(p1));
    chk({nm, ".p2"}, DW'(bus.Pending2), DW'(p2));
  endtask

  int n;

  initial begin
    idle();
    vt[0]  = mk(0, 0, '0, 7, 0, 1, 7, '0, '0, 0, 0);
    vt[1]  = mk(0, 0, '0, 7, 7, 0, 0, '0, '0, 1, 1);
    vt[2]  = mk(1, 7, 64'h1234, 7, 3, 0, 0, BYP ? 64'h1234 : 64'h0, '0, !BYP, 0);
    vt[3]  = mk(0, 0, '0, 7, 7, 0, 0, 64'h1234, 64'h1234, 0, 0);
    vt[4]  = mk(1, 31, '1, 31, 31, 1, 31, '0, '0, 0, 0);
    vt[5]  = mk(0, 0, '0, 31, 7, 0, 0, '0, 64'h1234, 0, 0);
    vt[6]  = mk(1, 9, 64'hAA, 9, 9, 1, 9, BYP ? 64'hAA : 64'h0, BYP ? 64'hAA : 64'h0, 0, 0);
    vt[7]  = mk(0, 0, '0, 9, 9, 0, 0, 64'hAA, 64'hAA, 1, 1);
    vt[8]  = mk(0, 0, '0, 12, 0, 1, 12, '0, '0, 0, 0);
    vt[9]  = mk(1, 12, 64'h55, 12, 12, 0, 0, BYP ? 64'h55 : 64'h0, BYP ? 64'h55 : 64'h0, !BYP, !BYP);
    vt[10] = mk(0, 0, '0, 12, 9, 0, 0, 64'h55, 64'hAA, 0, 1);
    vt[11] = mk(0, 0, '0, 9, 12, 1, 9, 64'hAA, 64'h55, 1, 0);
    vt[12] = mk(1, 9, 64'hBB, 9, 1, 0, 0, BYP ? 64'hBB : 64'hAA, '0, !BYP, 0);
    vt[13] = mk(0, 0, '0, 9, 9, 0, 0, 64'hBB, 64'hBB, 0, 0);

    // Initial reset and clear
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_ready(n);
    vectors++;
    chk("init_clear_cycles", DW'(n), DW'(32));

    // Preload reg 5, then reset; write to reg 3 during CLEAR must be lost
    write_issue(5, 64'hDEAD, 1'b0, 0);
    read_chk("preload5", 5, 0, 64'hDEAD, '0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    chk("reset_ready", DW'(bus.ready), '0);
    chk("reset_rd1", bus.ReadData1, '0);
    @(negedge clk);
    reset = 1'b0;
    bus.RegWrite = 1'b1; bus.WriteRegister = AW'(3); bus.WriteData = 64'h77;
    bus.IssueValid = 1'b1; bus.IssueRegister = AW'(3);
    bus.ReadRegister1 = AW'(5);
    #1;
    vectors++;
    chk("clear_rd1_masked", bus.ReadData1, '0);
    chk("clear_p1_masked", DW'(bus.Pending1), '0);
    wait_ready(n);
    idle();
    vectors++;
    chk("clear_cycles", DW'(n), DW'(32));
    read_chk("after_clear", 5, 3, '0, '0, 0, 0);

    // Main vector table
    foreach (vt[i]) begin
      @(negedge clk);
      bus.RegWrite = vt[i].rw; bus.WriteRegister = vt[i].wr; bus.WriteData = vt[i].wd;
      bus.ReadRegister1 = vt[i].rr1; bus.ReadRegister2 = vt[i].rr2;
      bus.IssueValid = vt[i].iv; bus.IssueRegister = vt[i].ir;
      #1;
      vectors++;
      chk($sformatf("vec%0d.rd1", i), bus.ReadData1, vt[i].e_rd1);
      chk($sformatf("vec%0d.rd2", i), bus.ReadData2, vt[i].e_rd2);
      chk($sformatf("vec%0d.p1", i), DW'(bus.Pending1), DW'(vt[i].e_p1));
      chk($sformatf("vec%0d.p2", i), DW'(bus.Pending2), DW'(vt[i].e_p2));
    end

    // ZERO_EN=0 instance: reg 31 is ordinary storage
    @(negedge clk);
    idle();
    bus2.RegWrite = 1'b1; bus2.WriteRegister = AW'(31); bus2.WriteData = '1;
    @(negedge clk);
    idle();
    bus2.ReadRegister1 = AW'(31);
    #1;
    vectors++;
    chk("nozero_rd31", bus2.ReadData1, '1);

    // Reset in RUN with pending bits, then reset again mid-clear at index 10
    for (int r = 1; r <= 4; r++)
      write_issue(r, DW'(r * 16 + 1), (r % 2) == 0, r);
    read_chk("pre_reset", 2, 4, 64'h21, 64'h41, 1, 1);
    read_chk("pre_reset13", 1, 3, 64'h11, 64'h31, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    bus.ReadRegister1 = AW'(2);
    @(posedge clk); #1;
    vectors++;
    chk("run_reset_p1", DW'(bus.Pending1), '0);
    chk("run_reset_ready", DW'(bus.ready), '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_ready(n);
    vectors++;
    chk("midclear_cycles", DW'(n), DW'(32));
    read_chk("post_reset24", 2, 4, '0, '0, 0, 0);
    read_chk("post_reset13", 1, 3, '0, '0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
